// File: rtl/sdram_host_bridge.sv
// rtl/sdram_host_bridge.sv - host access/ack bus to SDRAM toggle req/ack port bridge
// Host writes are posted into a FIFO; reads issue only once the FIFO has drained.
module sdram_host_bridge #(
  parameter int ADDR_W     = 24,
  parameter int WBUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h_access,
  input  logic              h_wr_en,
  input  logic [1:0]        h_bytesel,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [15:0]       h_wdata,
  output logic [15:0]       h_rdata,
  output logic              h_ack,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_wrl,
  output logic              s_wrh,
  output logic [15:0]       s_din,
  input  logic [15:0]       s_dout,
  output logic              s_req,
  input  logic              s_ack,
  input  logic              cfg_done,
  output logic              wbuf_empty,
  output logic              busy
);
  localparam int IDX_W = $clog2(WBUF_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int ENT_W = ADDR_W + 18;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_WR, S_WAIT_RD} state_t;
  state_t state, state_next;

  logic [ENT_W-1:0] wbuf [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [ENT_W-1:0] head;
  logic             ack_d;
  logic             fifo_empty, fifo_full, holdoff, pending;
  logic             wr_accept, push, pop, issue_wr, issue_rd, rd_done;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                      (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign head       = wbuf[rd_ptr[IDX_W-1:0]];
  // Host access is blind during the ack pulse and the cycle after it.
  assign holdoff    = h_ack | ack_d;
  assign pending    = s_req ^ s_ack;
  assign wr_accept  = h_access & h_wr_en & ~holdoff & (~fifo_full | pop);
  assign push       = wr_accept & (|h_bytesel);

  assign wbuf_empty = fifo_empty && (state != S_WAIT_WR);
  assign busy       = (state != S_IDLE) || !fifo_empty;

  always_comb begin
    state_next = state;
    issue_wr   = 1'b0;
    issue_rd   = 1'b0;
    pop        = 1'b0;
    rd_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_done) begin
          if (!fifo_empty) begin
            issue_wr   = 1'b1;
            state_next = S_WAIT_WR;
          end else if (h_access && !h_wr_en && !holdoff) begin
            issue_rd   = 1'b1;
            state_next = S_WAIT_RD;
          end
        end
      end
      S_WAIT_WR: begin
        if (!pending) begin
          pop        = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_WAIT_RD: begin
        if (!pending) begin
          rd_done    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ack_d   <= 1'b0;
      h_ack   <= 1'b0;
      h_rdata <= '0;
      s_req   <= s_ack;
      s_addr  <= '0;
      s_din   <= '0;
      s_wrl   <= 1'b0;
      s_wrh   <= 1'b0;
    end else begin
      state <= state_next;
      ack_d <= h_ack;
      h_ack <= wr_accept | rd_done;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (rd_done) h_rdata <= s_dout;
      if (issue_wr) begin
        s_addr <= head[ENT_W-1 -: ADDR_W];
        s_din  <= head[17:2];
        s_wrl  <= head[0];
        s_wrh  <= head[1];
        s_req  <= ~s_req;
      end else if (issue_rd) begin
        s_addr <= h_addr;
        s_wrl  <= 1'b0;
        s_wrh  <= 1'b0;
        s_req  <= ~s_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) wbuf[wr_ptr[IDX_W-1:0]] <= {h_addr, h_wdata, h_bytesel};
  end
endmodule

// File: tb/tb_sdram_host_bridge.sv
// tb/tb_sdram_host_bridge.sv - scoreboard bench for sdram_host_bridge with a toggle-protocol SDRAM model
module tb_sdram_host_bridge;
  logic        clk = 1'b0, reset = 1'b1;
  logic        h_access = 1'b0, h_wr_en = 1'b0, cfg_done = 1'b1;
  logic [1:0]  h_bytesel = 2'b00;
  logic [23:0] h_addr = '0;
  logic [15:0] h_wdata = '0;
  logic [15:0] h_rdata, s_din;
  logic [15:0] s_dout = '0;
  logic        h_ack, s_wrl, s_wrh, s_req, wbuf_empty, busy;
  logic [23:0] s_addr;
  logic        s_ack = 1'b1;

  int checks = 0, failures = 0, cyc = 0;

  sdram_host_bridge #(.ADDR_W(24), .WBUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .h_access(h_access), .h_wr_en(h_wr_en),
    .h_bytesel(h_bytesel), .h_addr(h_addr), .h_wdata(h_wdata), .h_rdata(h_rdata),
    .h_ack(h_ack), .s_addr(s_addr), .s_wrl(s_wrl), .s_wrh(s_wrh), .s_din(s_din),
    .s_dout(s_dout), .s_req(s_req), .s_ack(s_ack), .cfg_done(cfg_done),
    .wbuf_empty(wbuf_empty), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
    logic        wrl;
    logic        wrh;
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] rexp_q[$];
  logic [15:0] mmem    [logic [23:0]];
  logic [15:0] ref_mem [logic [23:0]];

  function automatic logic [15:0] init_word(input logic [23:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // SDRAM port model: acks model_delay negedges after it sees a new request
  int          model_delay = 6;
  bit          m_active = 0, m_bad = 0;
  int          m_cnt = 0, m_txns = 0, m_ack_cyc = 0;
  logic [23:0] m_addr;
  logic [15:0] m_din, cur;
  logic        m_wrl, m_wrh, m_req;
  txn_t        e;

  always @(negedge clk) begin
    if (m_active) begin
      if (!reset && (s_req !== m_req || s_addr !== m_addr || s_wrl !== m_wrl ||
                     s_wrh !== m_wrh || ((m_wrl || m_wrh) && s_din !== m_din)))
        m_bad = 1;
      m_cnt--;
      if (m_cnt == 0) begin
        cur = mmem.exists(m_addr) ? mmem[m_addr] : init_word(m_addr);
        if (m_wrl) cur[7:0] = m_din[7:0];
        if (m_wrh) cur[15:8] = m_din[15:8];
        if (m_wrl || m_wrh) mmem[m_addr] = cur;
        else s_dout = cur;
        s_ack = ~s_ack;
        m_active = 0;
        m_ack_cyc = cyc;
        checks++;
        if (m_bad) begin
          failures++;
          $display("FAIL req_stable addr=%h: port outputs changed while pending", m_addr);
        end
      end
    end else if (s_req !== s_ack) begin
      m_active = 1;
      m_cnt = model_delay;
      m_req = s_req; m_addr = s_addr; m_din = s_din; m_wrl = s_wrl; m_wrh = s_wrh;
      m_bad = 0;
      m_txns++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_txn unexpected request addr=%h wrl=%b wrh=%b", s_addr, s_wrl, s_wrh);
      end else begin
        e = exp_q.pop_front();
        if (s_addr !== e.addr || s_wrl !== e.wrl || s_wrh !== e.wrh ||
            ((e.wrl || e.wrh) && s_din !== e.data)) begin
          failures++;
          $display("FAIL sb_txn got addr=%h din=%h wrl=%b wrh=%b want addr=%h din=%h wrl=%b wrh=%b",
                   s_addr, s_din, s_wrl, s_wrh, e.addr, e.data, e.wrl, e.wrh);
        end
      end
    end
  end

  task automatic host_write(input logic [23:0] a, input logic [15:0] d, input logic [1:0] bs,
                            output int lat, output int ack_cyc);
    logic [15:0] w;
    txn_t t;
    if (bs != 2'b00) begin
      t.addr = a; t.data = d; t.wrl = bs[0]; t.wrh = bs[1];
      exp_q.push_back(t);
      w = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
      if (bs[0]) w[7:0] = d[7:0];
      if (bs[1]) w[15:8] = d[15:8];
      ref_mem[a] = w;
    end
    h_access = 1'b1; h_wr_en = 1'b1; h_addr = a; h_wdata = d; h_bytesel = bs;
    lat = 0;
    do begin @(negedge clk); lat++; end while (h_ack !== 1'b1 && lat < 300);
    ack_cyc = cyc;
    checks++;
    if (h_ack !== 1'b1) begin
      failures++;
      $display("FAIL wr_ack_timeout addr=%h: h_ack=%b after %0d cycles, want 1", a, h_ack, lat);
    end
    h_access = 1'b0; h_wr_en = 1'b0;
    @(negedge clk);
    checks++;
    if (h_ack !== 1'b0) begin
      failures++;
      $display("FAIL wr_ack_pulse addr=%h: h_ack=%b after pulse, want 0", a, h_ack);
    end
    @(negedge clk);
  endtask

  task automatic host_read(input logic [23:0] a, output int lat);
    txn_t t;
    logic [15:0] want;
    t.addr = a; t.data = '0; t.wrl = 1'b0; t.wrh = 1'b0;
    exp_q.push_back(t);
    rexp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : init_word(a));
    h_access = 1'b1; h_wr_en = 1'b0; h_addr = a; h_bytesel = 2'b11;
    lat = 0;
    do begin @(negedge clk); lat++; end while (h_ack !== 1'b1 && lat < 300);
    want = rexp_q.pop_front();
    checks++;
    if (h_ack !== 1'b1 || h_rdata !== want) begin
      failures++;
      $display("FAIL rd_data addr=%h: h_ack=%b h_rdata=%h, want ack=1 rdata=%h", a, h_ack, h_rdata, want);
    end
    h_access = 1'b0;
    @(negedge clk);
    checks++;
    if (h_ack !== 1'b0 || h_rdata !== want) begin
      failures++;
      $display("FAIL rd_ack_pulse addr=%h: h_ack=%b h_rdata=%h, want ack=0 rdata held %h", a, h_ack, h_rdata, want);
    end
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((!wbuf_empty || busy || m_active) && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (!wbuf_empty || busy) begin
      failures++;
      $display("FAIL %s_drain: wbuf_empty=%b busy=%b after %0d cycles, want 1/0", tag, wbuf_empty, busy, n);
    end
  endtask

  task automatic test_reset();
    int toggles = 0;
    reset = 1'b1; cfg_done = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_req !== 1'b1 || h_ack !== 1'b0 || wbuf_empty !== 1'b1 || busy !== 1'b0 || h_rdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: s_req=%b h_ack=%b wbuf_empty=%b busy=%b h_rdata=%h, want 1 0 1 0 0000",
               s_req, h_ack, wbuf_empty, busy, h_rdata);
    end
    checks++;
    if (s_addr !== 24'h0 || s_din !== 16'h0 || s_wrl !== 1'b0 || s_wrh !== 1'b0) begin
      failures++;
      $display("FAIL reset_port: s_addr=%h s_din=%h wrl=%b wrh=%b, want all 0", s_addr, s_din, s_wrl, s_wrh);
    end
    repeat (20) begin @(negedge clk); if (s_req !== 1'b1) toggles++; end
    checks++;
    if (toggles != 0 || m_txns != 0) begin
      failures++;
      $display("FAIL reset_no_toggle: %0d toggled cycles, %0d requests, want 0 0", toggles, m_txns);
    end
  endtask

  task automatic test_single_write();
    int lat, ac;
    model_delay = 6;
    host_write(24'h000010, 16'h1234, 2'b11, lat, ac);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL single_wr_latency: %0d cycles, want 1", lat); end
    checks++;
    if (wbuf_empty !== 1'b0) begin failures++; $display("FAIL single_wr_inflight: wbuf_empty=%b, want 0", wbuf_empty); end
    wait_drain("single_wr");
    checks++;
    if (!mmem.exists(24'h000010) || mmem[24'h000010] !== 16'h1234) begin
      failures++;
      $display("FAIL single_wr_mem: write did not land as 1234");
    end
  endtask

  task automatic test_back_to_back();
    int lat, ac, n0;
    model_delay = 20;
    n0 = m_txns;
    for (int i = 0; i < 5; i++) begin
      host_write(24'h000100 + 24'(i), 16'hA000 + 16'(i), 2'b11, lat, ac);
      checks++;
      if (i < 4 && lat != 1) begin
        failures++;
        $display("FAIL b2b_latency write%0d: %0d cycles, want 1", i + 1, lat);
      end else if (i == 4 && (lat <= 1 || ac != m_ack_cyc + 1)) begin
        failures++;
        $display("FAIL b2b_stall write5: lat=%0d ack_cyc=%0d, want lat>1 ack_cyc=%0d", lat, ac, m_ack_cyc + 1);
      end
    end
    wait_drain("b2b");
    checks++;
    if (m_txns != n0 + 5 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: %0d requests, %0d left, want 5 0", m_txns - n0, exp_q.size());
    end
  endtask

  task automatic test_write_read_order();
    int lat, ac;
    model_delay = 6;
    host_read(24'h000030, lat);
    checks++;
    if (lat != 8) begin failures++; $display("FAIL rd_latency: %0d cycles, want 8", lat); end
    host_write(24'h000020, 16'hBEEF, 2'b10, lat, ac);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL raw_wr_latency: %0d cycles, want 1", lat); end
    host_read(24'h000020, lat);
    checks++;
    if (lat <= 8) begin failures++; $display("FAIL raw_rd_wait: read acked after %0d cycles, want >8", lat); end
  endtask

  task automatic test_byte_lanes();
    int lat, ac, n0;
    model_delay = 2;
    n0 = m_txns;
    host_write(24'h000020, 16'h7777, 2'b00, lat, ac);
    repeat (4) @(negedge clk);
    checks++;
    if (lat != 1 || m_txns != n0) begin
      failures++;
      $display("FAIL null_write: lat=%0d requests=%0d, want 1 0", lat, m_txns - n0);
    end
    host_write(24'h000020, 16'h0011, 2'b01, lat, ac);
    host_read(24'h000020, lat);
  endtask

  task automatic test_cfg_gate();
    int lat, ac, n0, bad_lat = 0;
    logic s0;
    model_delay = 3;
    cfg_done = 1'b0;
    s0 = s_req;
    n0 = m_txns;
    host_write(24'h000200, 16'h1111, 2'b11, lat, ac); if (lat != 1) bad_lat++;
    host_write(24'h000201, 16'h2222, 2'b01, lat, ac); if (lat != 1) bad_lat++;
    host_write(24'h000202, 16'h3333, 2'b10, lat, ac); if (lat != 1) bad_lat++;
    repeat (10) @(negedge clk);
    checks++;
    if (bad_lat != 0 || s_req !== s0 || m_txns != n0 || busy !== 1'b1 || wbuf_empty !== 1'b0) begin
      failures++;
      $display("FAIL cfg_hold: slow_acks=%0d s_req=%b(was %b) requests=%0d busy=%b wbuf_empty=%b, want 0 unchanged 0 1 0",
               bad_lat, s_req, s0, m_txns - n0, busy, wbuf_empty);
    end
    cfg_done = 1'b1;
    wait_drain("cfg");
    checks++;
    if (m_txns != n0 + 3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL cfg_release: %0d requests, %0d left, want 3 0", m_txns - n0, exp_q.size());
    end
  endtask

  task automatic test_reset_in_read();
    txn_t t;
    int n = 0, acks = 0, toggles = 0, n0;
    logic a0;
    model_delay = 3;
    t.addr = 24'h000300; t.data = '0; t.wrl = 1'b0; t.wrh = 1'b0;
    exp_q.push_back(t);
    h_access = 1'b1; h_wr_en = 1'b0; h_addr = 24'h000300;
    while (s_req === s_ack && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (s_req === s_ack) begin failures++; $display("FAIL rst_rd_issue: read never issued within %0d cycles", n); end
    reset = 1'b1; h_access = 1'b0;
    a0 = s_ack;
    @(negedge clk);
    if (h_ack === 1'b1) acks++;
    checks++;
    if (s_req !== s_ack) begin failures++; $display("FAIL rst_rd_req: s_req=%b s_ack=%b, want equal", s_req, s_ack); end
    repeat (5) begin @(negedge clk); if (h_ack === 1'b1) acks++; end
    reset = 1'b0;
    n0 = m_txns;
    repeat (20) begin
      @(negedge clk);
      if (h_ack === 1'b1) acks++;
      if (s_req !== s_ack) toggles++;
    end
    checks++;
    if (s_ack === a0 || acks != 0 || toggles != 0 || m_txns != n0 || h_rdata !== 16'h0) begin
      failures++;
      $display("FAIL rst_rd_quiet: late_ack_seen=%b h_acks=%0d pending_cycles=%0d new_requests=%0d h_rdata=%h, want 1 0 0 0 0000",
               s_ack !== a0, acks, toggles, m_txns - n0, h_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_write_read_order();
    test_byte_lanes();
    test_cfg_gate();
    test_reset_in_read();
    checks++;
    if (exp_q.size() != 0 || rexp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d txns %0d reads outstanding, want 0 0", exp_q.size(), rexp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
